// File: rtl/rast_hit_collector.sv
// Hit collector behind the rast sample-output port: up to two hits in per cycle,
// one out over valid/ready, with early almost-full warning and drop accounting.
module rast_hit_collector #(
  parameter int unsigned SIGFIG = 24,
  parameter int unsigned RADIX  = 10,
  parameter int unsigned AXIS   = 3,
  parameter int unsigned COLORS = 3,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned AF_GAP = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [AXIS-1:0][SIGFIG-1:0]     hit_R18S,
  input  logic                            hit_valid_R18H,
  input  logic [AXIS-1:0][SIGFIG-1:0]     hit_R18S_2,
  input  logic                            hit_valid_R18H_2,
  input  logic [COLORS-1:0][SIGFIG-1:0]   color_R18U,
  input  logic                            clear_H,
  output logic [AXIS-1:0][SIGFIG-1:0]     out_hit_S,
  output logic [COLORS-1:0][SIGFIG-1:0]   out_color_U,
  output logic                            out_valid_H,
  input  logic                            out_ready_H,
  output logic                            almostFull_L,
  output logic                            overflow_H,
  output logic [31:0]                     hitCnt_U,
  output logic [15:0]                     dropCnt_U
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned HW = AXIS * SIGFIG;
  localparam int unsigned KW = COLORS * SIGFIG;
  localparam int unsigned EW = HW + KW;

  if (RADIX >= SIGFIG) begin : g_bad_radix
    $error("RADIX must be smaller than SIGFIG");
  end
  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two and at least 4");
  end
  if (AF_GAP < 2 || AF_GAP >= DEPTH) begin : g_bad_gap
    $error("AF_GAP must satisfy 2 <= AF_GAP < DEPTH");
  end

  logic [EW-1:0] mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, wr_ptr_p1;
  logic [CW-1:0] count_q, count_d;
  logic [EW-1:0] head_q, head_d;
  logic          out_valid_q;
  logic          almost_full_l_q;
  logic          overflow_q, overflow_d;
  logic [31:0]   hit_cnt_q, hit_cnt_d;
  logic [15:0]   drop_cnt_q, drop_cnt_d;

  logic          pop;
  logic [1:0]    in_cnt;
  logic [CW:0]   space;
  logic [1:0]    accepted;
  logic [1:0]    dropped;
  logic          wr0_en, wr1_en;
  logic [EW-1:0] wr0_data, wr1_data;
  logic [16:0]   drop_sum;

  always_comb begin
    pop       = out_valid_q & out_ready_H;
    in_cnt    = {1'b0, hit_valid_R18H} + {1'b0, hit_valid_R18H_2};
    space     = (CW+1)'(DEPTH) - {1'b0, count_q} + (CW+1)'(pop);
    accepted  = ((CW+1)'(in_cnt) > space) ? space[1:0] : in_cnt;
    dropped   = in_cnt - accepted;
    wr0_en    = (accepted != 2'd0);
    wr1_en    = (accepted == 2'd2);
    // A lone secondary hit takes the first free slot.
    wr0_data  = hit_valid_R18H ? {hit_R18S, color_R18U} : {hit_R18S_2, color_R18U};
    wr1_data  = {hit_R18S_2, color_R18U};
    wr_ptr_p1 = wr_ptr_q + PW'(1);
    rd_ptr_d  = rd_ptr_q + PW'(pop);
    wr_ptr_d  = wr_ptr_q + PW'(accepted);
    count_d   = count_q + CW'(accepted) - CW'(pop);
  end

  // The next head may be a hit written on this very edge, so bypass storage then.
  always_comb begin
    head_d = head_q;
    if (count_d != '0) begin
      if (wr0_en && (rd_ptr_d == wr_ptr_q)) begin
        head_d = wr0_data;
      end else if (wr1_en && (rd_ptr_d == wr_ptr_p1)) begin
        head_d = wr1_data;
      end else begin
        head_d = mem_q[rd_ptr_d];
      end
    end
  end

  always_comb begin
    drop_sum   = {1'b0, drop_cnt_q} + 17'(dropped);
    hit_cnt_d  = hit_cnt_q + 32'(accepted);
    drop_cnt_d = drop_sum[16] ? '1 : drop_sum[15:0];
    overflow_d = overflow_q | (dropped != 2'd0);
    if (clear_H) begin
      hit_cnt_d  = '0;
      drop_cnt_d = '0;
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr0_en) begin
      mem_q[wr_ptr_q] <= wr0_data;
    end
    if (wr1_en) begin
      mem_q[wr_ptr_p1] <= wr1_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q        <= '0;
      wr_ptr_q        <= '0;
      count_q         <= '0;
      head_q          <= '0;
      out_valid_q     <= 1'b0;
      almost_full_l_q <= 1'b1;
      overflow_q      <= 1'b0;
      hit_cnt_q       <= '0;
      drop_cnt_q      <= '0;
    end else begin
      rd_ptr_q        <= rd_ptr_d;
      wr_ptr_q        <= wr_ptr_d;
      count_q         <= count_d;
      head_q          <= head_d;
      out_valid_q     <= (count_d != '0);
      almost_full_l_q <= !(count_d >= CW'(DEPTH - AF_GAP));
      overflow_q      <= overflow_d;
      hit_cnt_q       <= hit_cnt_d;
      drop_cnt_q      <= drop_cnt_d;
    end
  end

  assign out_hit_S    = head_q[EW-1 -: HW];
  assign out_color_U  = head_q[KW-1:0];
  assign out_valid_H  = out_valid_q;
  assign almostFull_L = almost_full_l_q;
  assign overflow_H   = overflow_q;
  assign hitCnt_U     = hit_cnt_q;
  assign dropCnt_U    = drop_cnt_q;

endmodule
